eject_scheduler: RTL and testbench

Sequences the local ejection port of a bufferless router. Each cycle it arbitrates between two ejection candidates (golden-packet flits first, then starvation-guard, then round-robin), grants at most one, and captures the granted flit into a small ejection FIFO. The FIFO drains to the local PE over a valid/ready handshake. The losing or ungranted candidate stays in the deflection path; the datapath uses `grant` to steer it.

---
 rtl/eject_scheduler.sv | 132 +++++++++++++
 tb/tb_eject_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/eject_scheduler.sv
// Ejection-port arbiter and FIFO for a bufferless router: golden > starved > round-robin.
// Optional starvation guard is enabled by defining EJECT_STARVE_GUARD_EN.
module eject_scheduler #(
  parameter int FLIT_W       = 64,
  parameter int DEPTH        = 4,
  parameter int ID_W         = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 cand_valid,
  input  logic [1:0]                 cand_golden,
  input  logic [ID_W-1:0]            cand_id0,
  input  logic [ID_W-1:0]            cand_id1,
  input  logic [FLIT_W-1:0]          cand_flit0,
  input  logic [FLIT_W-1:0]          cand_flit1,
  output logic [1:0]                 grant,
  output logic                       eject_valid,
  output logic [FLIT_W-1:0]          eject_flit,
  input  logic                       eject_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              rr_ptr_reg;
  logic              eject_valid_reg;
  logic [FLIT_W-1:0] eject_flit_reg;

  logic              open;
  logic [1:0]        grant_c;
  logic              rr_used;
  logic [1:0]        starved;
  logic              push, pop;
  logic [FLIT_W-1:0] push_data;

  assign open = (count_reg < DEPTH_C);

`ifdef EJECT_STARVE_GUARD_EN
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  for (genvar gi = 0; gi < 2; gi++) begin : g_starve
    logic [SW-1:0] starve_reg;
    // Counts only cycles where the FIFO could have accepted this candidate.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        starve_reg <= '0;
      else if (!cand_valid[gi] || grant_c[gi])
        starve_reg <= '0;
      else if (open && starve_reg != LIMIT_C)
        starve_reg <= starve_reg + SW'(1);
    end
    assign starved[gi] = (starve_reg >= LIMIT_C);
  end
`else
  assign starved = 2'b00;
`endif

  always_comb begin
    grant_c = 2'b00;
    rr_used = 1'b0;
    if (reset && open) begin
      case (cand_valid)
        2'b01: grant_c = 2'b01;
        2'b10: grant_c = 2'b10;
        2'b11: begin
          if (cand_golden == 2'b01)
            grant_c = 2'b01;
          else if (cand_golden == 2'b10)
            grant_c = 2'b10;
          else if (cand_golden == 2'b11)
            grant_c = (cand_id1 < cand_id0) ? 2'b10 : 2'b01;
          else if (starved == 2'b01)
            grant_c = 2'b01;
          else if (starved == 2'b10)
            grant_c = 2'b10;
          else begin
            grant_c = rr_ptr_reg ? 2'b10 : 2'b01;
            rr_used = 1'b1;
          end
        end
        default: grant_c = 2'b00;
      endcase
    end
  end

  assign grant     = grant_c;
  assign push      = |grant_c;
  assign push_data = grant_c[1] ? cand_flit1 : cand_flit0;
  assign pop       = eject_valid_reg && eject_ready;

  assign rd_ptr_next = rd_ptr_reg + PW'(pop);
  assign count_next  = count_reg + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      rr_ptr_reg      <= 1'b0;
      eject_valid_reg <= 1'b0;
      eject_flit_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (rr_used)
        rr_ptr_reg <= grant_c[0];
      eject_valid_reg <= (count_next != '0);
      // A push into an otherwise-empty FIFO becomes the head directly.
      if (count_next != '0)
        eject_flit_reg <= (push && wr_ptr_reg == rd_ptr_next) ? push_data : mem[rd_ptr_next];
    end
  end

  assign eject_valid = eject_valid_reg;
  assign eject_flit  = eject_flit_reg;
  assign fifo_count  = count_reg;

endmodule

// File: tb/tb_eject_scheduler.sv
// Self-checking bench for eject_scheduler: directed steps plus random traffic against a queue model.
module tb_eject_scheduler;

  localparam int DEPTH = 4;
  localparam int LIMIT = 7;

  logic        clk;
  logic        reset;
  logic [1:0]  cand_valid, cand_golden;
  logic [3:0]  cand_id0, cand_id1;
  logic [63:0] cand_flit0, cand_flit1;
  logic [1:0]  grant;
  logic        eject_valid;
  logic [63:0] eject_flit;
  logic        eject_ready;
  logic [2:0]  fifo_count;

  eject_scheduler dut (
    .clk(clk), .reset(reset),
    .cand_valid(cand_valid), .cand_golden(cand_golden),
    .cand_id0(cand_id0), .cand_id1(cand_id1),
    .cand_flit0(cand_flit0), .cand_flit1(cand_flit1),
    .grant(grant), .eject_valid(eject_valid), .eject_flit(eject_flit),
    .eject_ready(eject_ready), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference model state
  logic [63:0] q[$];
  int          rr = 0;
  int          starve[2] = '{0, 0};

  logic [1:0]  obs_grant;
  logic        obs_valid;
  logic [63:0] obs_flit;
  logic [2:0]  obs_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] ref_pick(output bit used_rr);
    bit s0, s1;
    used_rr = 0;
    if (q.size() >= DEPTH || cand_valid == 2'b00) return 2'b00;
    if (cand_valid == 2'b01) return 2'b01;
    if (cand_valid == 2'b10) return 2'b10;
    if (cand_golden == 2'b01) return 2'b01;
    if (cand_golden == 2'b10) return 2'b10;
    if (cand_golden == 2'b11) return (cand_id1 < cand_id0) ? 2'b10 : 2'b01;
`ifdef EJECT_STARVE_GUARD_EN
    s0 = starve[0] >= LIMIT;
    s1 = starve[1] >= LIMIT;
    if (s0 && !s1) return 2'b01;
    if (s1 && !s0) return 2'b10;
`else
    s0 = 0;
    s1 = 0;
`endif
    used_rr = 1;
    return (rr == 1) ? 2'b10 : 2'b01;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic [1:0] v, input logic [1:0] g, input logic [3:0] i0,
                      input logic [3:0] i1, input logic [63:0] f0, input logic [63:0] f1,
                      input logic rdy);
    logic [1:0] exp_g;
    bit used_rr, open, do_pop;
    cand_valid = v; cand_golden = g; cand_id0 = i0; cand_id1 = i1;
    cand_flit0 = f0; cand_flit1 = f1; eject_ready = rdy;
    #1;
    open  = q.size() < DEPTH;
    exp_g = ref_pick(used_rr);
    obs_grant = grant; obs_valid = eject_valid; obs_flit = eject_flit; obs_count = fifo_count;
    chk("grant", 64'(grant), 64'(exp_g));
    chk("eject_valid", 64'(eject_valid), 64'(q.size() > 0));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    if (q.size() > 0) chk("eject_flit", eject_flit, q[0]);
    $display("t=%0t v=%b g=%b id=%0d/%0d rdy=%b grant=%b exp=%b cnt=%0d", $time, v, g, i0, i1,
             rdy, grant, exp_g, fifo_count);
    @(posedge clk);
    do_pop = (q.size() > 0) && rdy;
    if (do_pop) void'(q.pop_front());
    if (exp_g != 2'b00) q.push_back(exp_g[1] ? f1 : f0);
    if (used_rr) rr = exp_g[0] ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      if (!v[i] || exp_g[i]) starve[i] = 0;
      else if (open && starve[i] < LIMIT) starve[i]++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_eject_valid", 64'(eject_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    q.delete(); rr = 0; starve = '{0, 0};
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cand_valid = 0; cand_golden = 0; cand_id0 = 0; cand_id1 = 0;
    cand_flit0 = 0; cand_flit1 = 0; eject_ready = 0;
    @(posedge clk); #1;
    chk("reset_flit", eject_flit, 64'd0);
    do_reset();

    // Single candidate, then its flit at the head one cycle later
    step(2'b01, 2'b00, 0, 0, 64'hA5, 64'h11, 1'b0);
    chk("tp1_grant", 64'(obs_grant), 64'h1);
    step(2'b00, 2'b00, 0, 0, 64'h0, 64'h0, 1'b1);
    chk("tp1_valid", 64'(obs_valid), 64'h1);
    chk("tp1_flit", obs_flit, 64'hA5);
    chk("tp1_count", 64'(obs_count), 64'h1);

    // Golden priority and id tie-break
    step(2'b11, 2'b10, 0, 0, 64'hB0, 64'hB1, 1'b1);
    chk("golden_one", 64'(obs_grant), 64'h2);
    step(2'b11, 2'b11, 5, 3, 64'hC0, 64'hC1, 1'b1);
    chk("golden_both", 64'(obs_grant), 64'h2);
    step(2'b11, 2'b11, 6, 6, 64'hD0, 64'hD1, 1'b1);
    chk("golden_tie", 64'(obs_grant), 64'h1);

    // Round-robin alternation
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b00, 0, 0, 64'(16'hE000 + k), 64'(16'hF000 + k), 1'b1);
      chk("rr_alt", 64'(obs_grant), (k % 2 == 0) ? 64'h1 : 64'h2);
    end

    // Fill to DEPTH with the PE stalled, then one pop
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(2'b01, 2'b00, 0, 0, 64'(32'h100 + k), 64'h0, 1'b0);
      chk("fill_grant", 64'(obs_grant), (k < DEPTH) ? 64'h1 : 64'h0);
    end
    step(2'b01, 2'b00, 0, 0, 64'h200, 64'h0, 1'b1);
    chk("full_count", 64'(obs_count), 64'd4);
    chk("full_pop_nogrant", 64'(obs_grant), 64'h0);
    step(2'b01, 2'b00, 0, 0, 64'h201, 64'h0, 1'b0);
    chk("after_pop_count", 64'(obs_count), 64'd3);
    chk("after_pop_grant", 64'(obs_grant), 64'h1);

    // Golden overrides starvation; starved candidate wins once golden clears
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(2'b11, 2'b01, 0, 0, 64'(32'h300 + k), 64'h3FF, 1'b1);
      chk("golden_hold", 64'(obs_grant), 64'h1);
    end
    step(2'b11, 2'b00, 0, 0, 64'h310, 64'h311, 1'b1);
`ifdef EJECT_STARVE_GUARD_EN
    chk("starve_win", 64'(obs_grant), 64'h2);
`else
    chk("starve_off_rr", 64'(obs_grant), 64'h1);
`endif

    // Reset with buffered flits discards them
    do_reset();
    for (int k = 0; k < 3; k++) step(2'b01, 2'b00, 0, 0, 64'(32'hDEAD0 + k), 64'h0, 1'b0);
    cand_valid = 2'b01;
    do_reset();
    for (int k = 0; k < 3; k++) step(2'b00, 2'b00, 0, 0, 64'h0, 64'h0, 1'b1);
    step(2'b10, 2'b00, 0, 0, 64'h0, 64'h5EED, 1'b0);
    step(2'b00, 2'b00, 0, 0, 64'h0, 64'h0, 1'b0);
    chk("post_rst_flit", obs_flit, 64'h5EED);
    step(2'b00, 2'b00, 0, 0, 64'h0, 64'h0, 1'b1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(2'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
